fir_param: RTL
==============

# fir_param

Parametrised, pipelined, valid-qualified FIR filter with runtime-loadable coefficients, round-half-up output scaling and saturation. It is the generalised successor of the team's fixed 9-tap, 16-bit low-pass FIR. It sits in the sample datapath between the ADC front-end capture and downstream decimation/processing. It accepts at most one sample per clock and produces one filtered sample per accepted input after a fixed latency.

## Interface
Parameters:
- DATA_W, default 16: input and output sample width, two's complement.
- COEF_W, default 16: coefficient width, two's complement (Q(COEF_W-OUT_SHIFT-1).OUT_SHIFT).
- TAPS, default 9: number of taps, ≥2.
- OUT_SHIFT, default 14: arithmetic right shift applied to the accumulator before saturation, ≥1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is a new sample this cycle.
- in_data  in  DATA_W  signed input sample.
- flush  in  1  synchronous clear of the delay line.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW=clog2(TAPS)  tap index to write.
- coef_data  in  COEF_W  signed coefficient value.
- out_valid  out  1  out_data carries a filtered sample.
- out_data  out  DATA_W  signed, rounded, saturated result.
- out_sat  out  1  qualifies out_data; high when saturation occurred for this sample.

## Operation
- Delay line x[0..TAPS-1]: on in_valid, x[0]←in_data and x[k]←x[k-1]. Without in_valid, the delay line holds.
- flush: x[k]←0 for all k. If flush and in_valid occur together, x[0]←in_data and all other taps become 0. In-flight pipeline data is not cleared and emerges normally.
- Coefficient bank coef[0..TAPS-1] is written when coef_we is high. Writes with coef_addr ≥ TAPS are ignored. A write takes effect at that edge; products formed from the next cycle on use the new value.
- Product stage: p[k] = x[k]·coef[k], full width DATA_W+COEF_W.
- Adder tree: L = clog2(TAPS) registered levels of pairwise sums, sign-extended one bit per level. An odd element passes through its level unchanged. ACC_W = DATA_W+COEF_W+L.
- Output stage:
  - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half toward +∞.
  - r > 2^(DATA_W-1)-1 → max positive, out_sat=1.
  - r < -2^(DATA_W-1) → min negative, out_sat=1.
  - Otherwise out_data=r and out_sat=0.
- A valid bit travels alongside every pipeline stage. The pipeline advances every cycle; there is no backpressure. Bubbles propagate with valid=0.
- out_data and out_sat update only when the valid bit reaches the output stage. Otherwise they hold their last value.

## Timing
- Latency: in_valid sampled at edge N → out_valid high after edge N+3+L. The stages are delay-line, product, L tree levels, output. For TAPS=9, L=4 and latency is 7 cycles.
- Throughput: one sample per clock. out_valid pattern equals the in_valid pattern delayed by latency.
- Reset (async assert, synchronous release): delay line, coefficients, products, sums and valid pipe all 0. out_valid=0, out_data=0, out_sat=0. Reset mid-stream discards all in-flight samples; no out_valid is produced for them.
- A coefficient write in the same cycle as in_valid: that sample's products use the new coefficient.
- Reset and coef_we together: reset wins.

## Structure
- Shared package fir_pkg:
  - clog2 function.
  - ACC_W derivation function.
  - Round/saturate function, reusable by the decimator.
- One sub-module: fir_adder_tree. Parametrised by N inputs and input width, it contains the registered pairwise reduction and valid pipe, with latency clog2(N).
- fir_param holds the delay line, coefficient bank, product stage, output stage and instantiates fir_adder_tree.

## Test plan
- Impulse: load coef[k]=0x4000 for k=3 only, others 0. Feed 1000 then zeros, continuous valid. Required: output sample index 3 = 1000, all others 0; first out_valid 7 cycles after first input.
- Rounding: coef[0]=0x2000, others 0. Inputs 3, -3, 1. Required outputs 2, -1, 1 (1.5→2, -1.5→-1, 0.5→1).
- Saturation: all 9 coefs 0x4000. Constant 32767 gives 32767 with out_sat=1; constant -32768 gives -32768 with out_sat=1. Input 100 gives 900 with out_sat=0.
- Valid gaps and flush:
  - Alternate in_valid 1/0 with an identical input sequence; outputs match the gapless run and out_valid mirrors the gaps.
  - Flush mid-stream; subsequent outputs equal a fresh-start response.
- Coefficient update mid-stream: constant input 1000, coef[0] changed 0x4000→0x2000 at cycle T. Required: outputs switch from 1000 to 500 exactly at the sample entering the product stage at T+1. Write to coef_addr=9 changes nothing.
- Reset mid-operation: assert rst with 5 samples in flight. Required: out_valid, out_data and out_sat read 0 immediately; no valid outputs after release until new inputs plus 7 cycles; coefficients read back as zero response.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR helpers: width derivation and the round-half-up / saturate step
// that the filter and the decimator both apply to their accumulators.
package fir_pkg;

  localparam int ACC_MAX_W = 64;

  typedef struct packed {
    logic                        sat;
    logic signed [ACC_MAX_W-1:0] val;
  } rs_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  // The 65-bit intermediate keeps the rounding add from overflowing a full 64-bit accumulator.
  function automatic rs_t round_sat(input logic signed [ACC_MAX_W-1:0] acc,
                                    input int shift, input int out_w);
    logic signed [ACC_MAX_W:0] t;
    logic signed [ACC_MAX_W:0] max_v;
    logic signed [ACC_MAX_W:0] min_v;
    rs_t rs;
    t     = (65'(acc) + (65'sd1 <<< (shift - 1))) >>> shift;
    max_v = (65'sd1 <<< (out_w - 1)) - 65'sd1;
    min_v = -(65'sd1 <<< (out_w - 1));
    rs.sat = 1'b1;
    if (t > max_v) begin
      rs.val = 64'(max_v);
    end else if (t < min_v) begin
      rs.val = 64'(min_v);
    end else begin
      rs.val = 64'(t);
      rs.sat = 1'b0;
    end
    return rs;
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Registered pairwise reduction of N signed operands; latency clog2(N) cycles,
// with the valid bit carried alongside each level.
module fir_adder_tree import fir_pkg::*; #(
  parameter int N    = 9,
  parameter int IN_W = 32,
  localparam int L     = clog2(N),
  localparam int OUT_W = IN_W + L
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [N*IN_W-1:0] in_data,
  output logic              out_vld,
  output logic [OUT_W-1:0]  out_sum
);

  logic [L-1:0] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      for (int i = 1; i < L; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign out_vld = vld_pipe[L-1];

  // Level l holds ceil(N/2^l) sums, one bit wider than level l-1; an odd last element passes through.
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int CNT = (N + (1 << l) - 1) >> l;
    localparam int W   = IN_W + l;
    logic signed [W-1:0] s [CNT];

    if (l == 0) begin : g_in
      for (genvar i = 0; i < N; i++) begin : g_n
        assign s[i] = $signed(in_data[i*IN_W +: IN_W]);
      end
    end else begin : g_sum
      localparam int PCNT = (N + (1 << (l - 1)) - 1) >> (l - 1);
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < CNT; i++) s[i] <= '0;
        end else begin
          for (int i = 0; i < CNT; i++) begin
            s[i] <= (2*i + 1 < PCNT)
                    ? W'(g_lvl[l-1].s[2*i]) + W'(g_lvl[l-1].s[(2*i + 1 < PCNT) ? 2*i + 1 : 2*i])
                    : W'(g_lvl[l-1].s[2*i]);
          end
        end
      end
    end
  end

  assign out_sum = g_lvl[L].s[0];

endmodule

// File: rtl/fir_param.sv
// Parametrised pipelined FIR: delay line, loadable coefficient bank, products,
// registered adder tree, then round-half-up and saturation to DATA_W.
module fir_param import fir_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 9,
  parameter int OUT_SHIFT = 14,
  localparam int AW = clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);

  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);

  logic signed [DATA_W-1:0] x_p0 [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [PW-1:0]     prod_p1 [TAPS];
  logic [TAPS*PW-1:0]       prod_flat;
  logic [ACC_W-1:0]         acc_tree;
  logic                     vld_p0, vld_p1, vld_tree;
  rs_t                      rs;

  // stage p0: delay line; flush clears every tap except one being loaded this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      for (int k = 0; k < TAPS; k++) x_p0[k] <= '0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid)   x_p0[0] <= $signed(in_data);
      else if (flush) x_p0[0] <= '0;
      for (int k = 1; k < TAPS; k++) begin
        if (flush)         x_p0[k] <= '0;
        else if (in_valid) x_p0[k] <= x_p0[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
    end else if (coef_we) begin
      for (int k = 0; k < TAPS; k++)
        if (32'(coef_addr) == k) coef[k] <= $signed(coef_data);
    end
  end

  // stage p1: full-width products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < TAPS; k++) prod_p1[k] <= '0;
    end else begin
      vld_p1 <= vld_p0;
      for (int k = 0; k < TAPS; k++) prod_p1[k] <= PW'(x_p0[k]) * PW'(coef[k]);
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_flat
    assign prod_flat[k*PW +: PW] = prod_p1[k];
  end

  fir_adder_tree #(.N(TAPS), .IN_W(PW)) u_tree (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (vld_p1),
    .in_data (prod_flat),
    .out_vld (vld_tree),
    .out_sum (acc_tree)
  );

  always_comb rs = round_sat(64'($signed(acc_tree)), OUT_SHIFT, DATA_W);

  // output stage: data and saturation flag hold between valid samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= vld_tree;
      if (vld_tree) begin
        out_data <= DATA_W'(rs.val);
        out_sat  <= rs.sat;
      end
    end
  end

endmodule
